// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: memory-wait freeze,
// branch flush and load-use interlock, plus sticky timeout flag and statistics counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_reg_wr_addr_i,
  input  logic             ex_reg_wr_sig_i,
  input  logic             ex_is_load_i,
  input  logic             br_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             flush_if_id_o,
  output logic             hold_id_ex_o,
  output logic             bubble_id_ex_o,
  output logic             hold_ex_mem_o,
  output logic             bubble_mem_wb_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          timeout_set;
  logic          timeout_hit;
  logic          freeze;
  logic          load_use;
  logic          rs1_match;
  logic          rs2_match;
  logic          stall_inc;
  logic          flush_inc;

  assign timeout_hit = (state == MEM_WAIT) && (timer == TW'(MEM_TIMEOUT - 1));
  assign freeze      = mem_req_i && !mem_ack_i && !timeout_hit;

  assign rs1_match = id_rs1_used_i && (id_rs1_addr_i == ex_reg_wr_addr_i);
  assign rs2_match = id_rs2_used_i && (id_rs2_addr_i == ex_reg_wr_addr_i);
  assign load_use  = ex_is_load_i && ex_reg_wr_sig_i && (ex_reg_wr_addr_i != 5'd0) &&
                     (rs1_match || rs2_match);

  assign stall_inc = freeze || (load_use && !br_taken_i);
  assign flush_inc = br_taken_i && !freeze;

  // Priority: memory freeze, then branch flush, then load-use interlock.
  always_comb begin
    hold_pc_o       = 1'b0;
    hold_if_id_o    = 1'b0;
    flush_if_id_o   = 1'b0;
    hold_id_ex_o    = 1'b0;
    bubble_id_ex_o  = 1'b0;
    hold_ex_mem_o   = 1'b0;
    bubble_mem_wb_o = 1'b0;
    if (!reset) begin
      if (freeze) begin
        hold_pc_o       = 1'b1;
        hold_if_id_o    = 1'b1;
        hold_id_ex_o    = 1'b1;
        hold_ex_mem_o   = 1'b1;
        bubble_mem_wb_o = 1'b1;
      end else if (br_taken_i) begin
        flush_if_id_o  = 1'b1;
        bubble_id_ex_o = 1'b1;
      end else if (load_use) begin
        hold_pc_o      = 1'b1;
        hold_if_id_o   = 1'b1;
        bubble_id_ex_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt = MEM_WAIT;
          timer_nxt = TW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i || !mem_req_i) begin
          state_nxt = RUN;
          timer_nxt = '0;
        end else if (timeout_hit) begin
          state_nxt   = RUN;
          timer_nxt   = '0;
          timeout_set = 1'b1;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      timer         <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (timeout_set) begin
        mem_timeout_o <= 1'b1;
      end
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_inc && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_o != {CNT_W{1'b1}})) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
